// File: rtl/dogx_startup_sequencer.sv
// rtl/dogx_startup_sequencer.sv - DOGX converter startup: reset hold, oscillator settle, offset calibration, run
// Offset calibration (CAL state and accumulator) is built only when DOGX_OFFSET_CAL_EN is defined.
module dogx_startup_sequencer #(
    parameter int DATA_W        = 11,
    parameter int DIV           = 8,
    parameter int HOLD_CYCLES   = 16,
    parameter int SETTLE_CYCLES = 1024,
    parameter int CAL_LOG2      = 6
) (
    input  logic                     CLK_24M,
    input  logic                     reset,
    input  logic                     start,
    input  logic signed [DATA_W-1:0] converter_output,
    input  logic                     alpha,
    output logic                     conv_reset_n,
    output logic                     sample_en,
    output logic                     busy,
    output logic                     cal_done,
    output logic signed [DATA_W-1:0] offset,
    output logic signed [DATA_W-1:0] data_out,
    output logic                     data_valid,
    output logic                     alpha_out
);

    localparam int TMR_MAX = (HOLD_CYCLES > SETTLE_CYCLES) ? HOLD_CYCLES : SETTLE_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX) + 1;
    localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;

    if (DIV < 2 || CAL_LOG2 < 1 || HOLD_CYCLES < 1 || SETTLE_CYCLES < 1) begin : g_param_check
        $error("dogx_startup_sequencer: illegal parameter value");
    end

    typedef enum logic [2:0] {IDLE, HOLD, SETTLE, CAL, RUN} state_t;

    state_t              state_q, state_d;
    logic                start_q, start_d, start_edge;
    logic [TMR_W-1:0]    timer_q, timer_d;
    logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
    logic [DATA_W-1:0]   data_out_q, data_out_d;
    logic                data_valid_q, data_valid_d;
    logic                alpha_out_q, alpha_out_d;
    logic                strobing;
    logic [DATA_W-1:0]   offset_w;
    logic [DATA_W:0]     diff;
    logic [DATA_W-1:0]   corrected;

`ifdef DOGX_OFFSET_CAL_EN
    localparam int ACC_W = DATA_W + CAL_LOG2;
    localparam int CNT_W = CAL_LOG2 + 1;

    logic [ACC_W-1:0]  acc_q, acc_d, acc_next;
    logic [CNT_W-1:0]  cal_cnt_q, cal_cnt_d, cal_cnt_next;
    logic [DATA_W-1:0] offset_q, offset_d;

    assign offset_w = offset_q;
`else
    assign offset_w = '0;
`endif

    assign strobing     = (state_q == SETTLE) || (state_q == CAL) || (state_q == RUN);
    assign sample_en    = strobing && (div_cnt_q == DIV_W'(DIV - 1));
    assign conv_reset_n = strobing;
    assign busy         = (state_q == HOLD) || (state_q == SETTLE) || (state_q == CAL);
    assign cal_done     = (state_q == RUN);
    assign offset       = offset_w;
    assign data_out     = data_out_q;
    assign data_valid   = data_valid_q;
    assign alpha_out    = alpha_out_q;
    assign start_edge   = start & ~start_q;

    // One extra bit keeps the subtraction exact; saturate when the top two bits disagree.
    always_comb begin
        diff = {converter_output[DATA_W-1], converter_output} - {offset_w[DATA_W-1], offset_w};
        corrected = diff[DATA_W-1:0];
        if (diff[DATA_W] != diff[DATA_W-1]) begin
            corrected = diff[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
        end
    end

    always_comb begin
        state_d      = state_q;
        start_d      = start;
        timer_d      = '0;
        div_cnt_d    = '0;
        data_out_d   = data_out_q;
        alpha_out_d  = alpha_out_q;
        data_valid_d = 1'b0;
`ifdef DOGX_OFFSET_CAL_EN
        acc_d        = acc_q;
        cal_cnt_d    = cal_cnt_q;
        offset_d     = offset_q;
        acc_next     = acc_q + {{CAL_LOG2{converter_output[DATA_W-1]}}, converter_output};
        cal_cnt_next = cal_cnt_q + 1'b1;
`endif

        if (strobing) begin
            div_cnt_d = (div_cnt_q == DIV_W'(DIV - 1)) ? '0 : div_cnt_q + 1'b1;
        end

        case (state_q)
            IDLE: ;
            HOLD: begin
                if (timer_q == TMR_W'(HOLD_CYCLES - 1)) state_d = SETTLE;
                else                                    timer_d = timer_q + 1'b1;
            end
            SETTLE: begin
                if (timer_q == TMR_W'(SETTLE_CYCLES - 1)) begin
`ifdef DOGX_OFFSET_CAL_EN
                    state_d = CAL;
`else
                    state_d = RUN;
`endif
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
`ifdef DOGX_OFFSET_CAL_EN
            CAL: begin
                if (sample_en && !alpha) begin
                    acc_d     = acc_next;
                    cal_cnt_d = cal_cnt_next;
                    // Dropping the low CAL_LOG2 bits is an arithmetic shift, i.e. floor of the mean.
                    if (cal_cnt_next == CNT_W'(2 ** CAL_LOG2)) begin
                        offset_d = acc_next[ACC_W-1:CAL_LOG2];
                        state_d  = RUN;
                    end
                end
            end
`endif
            RUN: begin
                if (sample_en) begin
                    data_out_d   = corrected;
                    alpha_out_d  = alpha;
                    data_valid_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // A new start wins over anything computed above; previous results stay visible.
        if (start_edge) begin
            state_d      = HOLD;
            timer_d      = '0;
            div_cnt_d    = '0;
            data_out_d   = data_out_q;
            alpha_out_d  = alpha_out_q;
            data_valid_d = 1'b0;
`ifdef DOGX_OFFSET_CAL_EN
            acc_d        = '0;
            cal_cnt_d    = '0;
            offset_d     = offset_q;
`endif
        end
    end

    always_ff @(posedge CLK_24M or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            start_q      <= 1'b0;
            timer_q      <= '0;
            div_cnt_q    <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            alpha_out_q  <= 1'b0;
`ifdef DOGX_OFFSET_CAL_EN
            acc_q        <= '0;
            cal_cnt_q    <= '0;
            offset_q     <= '0;
`endif
        end else begin
            state_q      <= state_d;
            start_q      <= start_d;
            timer_q      <= timer_d;
            div_cnt_q    <= div_cnt_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            alpha_out_q  <= alpha_out_d;
`ifdef DOGX_OFFSET_CAL_EN
            acc_q        <= acc_d;
            cal_cnt_q    <= cal_cnt_d;
            offset_q     <= offset_d;
`endif
        end
    end

endmodule

// File: tb/tb_dogx_startup_sequencer.sv
// tb/tb_dogx_startup_sequencer.sv - self-checking bench for dogx_startup_sequencer
// Expected results follow DOGX_OFFSET_CAL_EN the same way the design does.
module tb_dogx_startup_sequencer;

    localparam int W      = 11;
    localparam int DIVN   = 8;
    localparam int HOLD   = 16;
    localparam int SETTLE = 32;
    localparam int CALL   = 2;
    localparam int NCAL   = 1 << CALL;
    localparam int MAXV   = (1 << (W - 1)) - 1;
    localparam int MINV   = -(1 << (W - 1));
`ifdef DOGX_OFFSET_CAL_EN
    localparam bit CAL_EN = 1'b1;
`else
    localparam bit CAL_EN = 1'b0;
`endif

    logic                clk;
    logic                rst_n;
    logic                start;
    logic signed [W-1:0] conv;
    logic                alpha;
    logic                conv_reset_n, sample_en, busy, cal_done, data_valid, alpha_out;
    logic signed [W-1:0] offset_o, data_out_o;

    int checks = 0;
    int errors = 0;

    dogx_startup_sequencer #(
        .DATA_W(W), .DIV(DIVN), .HOLD_CYCLES(HOLD), .SETTLE_CYCLES(SETTLE), .CAL_LOG2(CALL)
    ) dut (
        .CLK_24M(clk), .reset(rst_n), .start(start), .converter_output(conv), .alpha(alpha),
        .conv_reset_n(conv_reset_n), .sample_en(sample_en), .busy(busy), .cal_done(cal_done),
        .offset(offset_o), .data_out(data_out_o), .data_valid(data_valid), .alpha_out(alpha_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: time measured as edges elapsed since the start edge.
    bit m_start_q, m_active, m_caldone, m_alpha, m_valid;
    int m_k, m_cnt, m_sum, m_off, m_data;
    bit e_crn, e_sen, e_busy, e_cd;

    function automatic int floor_div(input int a, input int b);
        int q;
        q = a / b;
        if ((a % b != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    function automatic int clamp(input int v);
        if (v > MAXV) return MAXV;
        if (v < MINV) return MINV;
        return v;
    endfunction

    // 0 idle, 1 hold, 2 settle, 3 cal, 4 run
    function automatic int phase_of(input bit act, input int k, input bit done);
        if (!act) return 0;
        if (k < HOLD) return 1;
        if (k - HOLD < SETTLE) return 2;
        if (CAL_EN && !done) return 3;
        return 4;
    endfunction

    function automatic bit strobe_of(input bit act, input int k);
        return act && (k >= HOLD) && ((k - HOLD) % DIVN == DIVN - 1);
    endfunction

    always @(posedge clk or negedge rst_n) begin : model
        int ph;
        bit stb, edge_s, nvalid;
        if (!rst_n) begin
            m_start_q = 0; m_active = 0; m_caldone = 0; m_alpha = 0; m_valid = 0;
            m_k = 0; m_cnt = 0; m_sum = 0; m_off = 0; m_data = 0;
        end else begin
            edge_s    = start && !m_start_q;
            m_start_q = start;
            ph        = phase_of(m_active, m_k, m_caldone);
            stb       = strobe_of(m_active, m_k);
            nvalid    = 0;
            if (edge_s) begin
                m_active = 1; m_k = 0; m_cnt = 0; m_sum = 0; m_caldone = 0;
            end else if (m_active) begin
                if (ph == 3 && stb && !alpha) begin
                    m_sum = m_sum + int'(conv);
                    m_cnt = m_cnt + 1;
                    if (m_cnt == NCAL) begin
                        m_off     = floor_div(m_sum, NCAL);
                        m_caldone = 1;
                    end
                end else if (ph == 4 && stb) begin
                    m_data  = clamp(int'(conv) - m_off);
                    m_alpha = alpha;
                    nvalid  = 1;
                end
                m_k = m_k + 1;
            end
            m_valid = nvalid;
        end
        ph     = phase_of(m_active, m_k, m_caldone);
        e_crn  = (ph >= 2);
        e_busy = (ph >= 1) && (ph <= 3);
        e_cd   = (ph == 4);
        e_sen  = strobe_of(m_active, m_k);
    end

    always @(negedge clk) begin : compare
        logic [27:0] act_v, exp_v;
        act_v = {conv_reset_n, sample_en, busy, cal_done, offset_o, data_out_o, data_valid, alpha_out};
        exp_v = {e_crn, e_sen, e_busy, e_cd, W'(m_off), W'(m_data), m_valid, m_alpha};
        checks++;
        if (act_v !== exp_v) begin
            errors++;
            $display("FAIL cycle_model t=%0t actual=%h required=%h", $time, act_v, exp_v);
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic drive(input int mode, input int cval, inout int i);
        case (mode)
            0: begin alpha = 1'b0; conv = W'(cval); end
            1: if (e_sen) begin
                alpha = (i % 2 == 0);
                conv  = (i == 5 || i == 7) ? W'(3) : (i == 9 || i == 11) ? W'(4) : W'(77);
                i++;
            end
            default: begin
                alpha = ($urandom_range(0, 3) == 0);
                conv  = W'($urandom);
            end
        endcase
    endtask

    task automatic wait_run(input int mode, input int cval, inout int cyc);
        int i;
        i = 0;
        do begin
            @(negedge clk);
            start = 1'b0;
            cyc++;
            drive(mode, cval, i);
        end while (!cal_done && cyc < 2000);
        check("cal_done_reached", int'(cal_done), 1);
    endtask

    task automatic run_to_run(input int mode, input int cval, output int cyc);
        cyc   = 0;
        start = 1'b1;
        wait_run(mode, cval, cyc);
    endtask

    task automatic wait_valid(output bit prev_sen);
        int n;
        bit ps;
        n = 0;
        ps = 1'b0;
        do begin
            ps = sample_en;
            @(negedge clk);
            n++;
        end while (!data_valid && n < 100);
        prev_sen = ps;
        check("data_valid_seen", int'(data_valid), 1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, dummy, sen_cnt;
        bit ps;
        rst_n = 1'b0; start = 1'b0; alpha = 1'b0; conv = '0; dummy = 0;
        repeat (3) @(negedge clk);
        check("reset_outputs", int'({conv_reset_n, sample_en, busy, cal_done, offset_o,
                                     data_out_o, data_valid, alpha_out}), 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_no_busy", int'(busy), 0);

        // Startup timing, then constant -5 calibration.
        conv = W'(-5); alpha = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (15) @(negedge clk);
        check("conv_reset_n_at_16", int'(conv_reset_n), 0);
        @(negedge clk);
        check("conv_reset_n_at_17", int'(conv_reset_n), 1);
        repeat (6) @(negedge clk);
        check("sample_en_at_23", int'(sample_en), 0);
        @(negedge clk);
        check("sample_en_at_24", int'(sample_en), 1);
        repeat (8) @(negedge clk);
        check("sample_en_at_32", int'(sample_en), 1);
        cyc = 32;
        wait_run(0, -5, cyc);
        check("cal_latency_const", cyc, CAL_EN ? 81 : 49);
        check("offset_minus5", int'(offset_o), CAL_EN ? -5 : 0);
        wait_valid(ps);
        check("valid_after_strobe", int'(ps), 1);
        check("data_out_corrected", int'(data_out_o), CAL_EN ? 0 : -5);

        // Alternating alpha during calibration.
        run_to_run(1, 0, cyc);
        check("cal_latency_alpha_alt", cyc, CAL_EN ? 113 : 49);
        check("offset_floor_14_4", int'(offset_o), CAL_EN ? 3 : 0);

        // Saturation at both ends.
        run_to_run(0, -20, cyc);
        check("offset_minus20", int'(offset_o), CAL_EN ? -20 : 0);
        conv = W'(1020);
        wait_valid(ps);
        check("sat_high", int'(data_out_o), CAL_EN ? 1023 : 1020);
        run_to_run(0, 20, cyc);
        check("offset_plus20", int'(offset_o), CAL_EN ? 20 : 0);
        conv = W'(-1020);
        wait_valid(ps);
        check("sat_low", int'(data_out_o), CAL_EN ? -1024 : -1020);

        // Restart from RUN.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("restart_busy", int'(busy), 1);
        check("restart_conv_reset_n", int'(conv_reset_n), 0);
        check("restart_valid_low", int'(data_valid), 0);
        check("restart_offset_kept", int'(offset_o), CAL_EN ? 20 : 0);
        cyc = 1;
        wait_run(0, 7, cyc);
        check("restart_latency", cyc, CAL_EN ? 81 : 49);
        check("offset_plus7", int'(offset_o), CAL_EN ? 7 : 0);

        // Asynchronous reset in RUN.
        repeat (10) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_outputs", int'({conv_reset_n, sample_en, busy, cal_done, offset_o,
                                           data_out_o, data_valid, alpha_out}), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        sen_cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (sample_en) sen_cnt++;
        end
        check("no_strobe_after_reset", sen_cnt, 0);
        check("idle_after_reset", int'(conv_reset_n), 0);

        // Randomized data, alpha and restart points.
        for (int r = 0; r < 8; r++) begin
            if (r % 2 == 1) begin
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                repeat ($urandom_range(3, 90)) begin
                    @(negedge clk);
                    drive(2, 0, dummy);
                end
            end
            run_to_run(2, 0, cyc);
            repeat ($urandom_range(20, 60)) begin
                @(negedge clk);
                drive(2, 0, dummy);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
